// File: rtl/car_pkg.sv
// Shared car definitions: motor direction codes and the steering state/decision helper.
package car_pkg;

    localparam logic [1:0] BACKWARD = 2'd0;
    localparam logic [1:0] LEFT     = 2'd1;
    localparam logic [1:0] RIGHT    = 2'd2;
    localparam logic [1:0] FORWARD  = 2'd3;

    // State encoding equals the dir code so the state register drives the motor directly.
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_LEFT    = 2'd1,
        ST_RIGHT   = 2'd2,
        ST_FORWARD = 2'd3
    } steer_state_t;

    function automatic steer_state_t steer_next(
        input logic         c_on,
        input logic         l_on,
        input logic         r_on,
        input steer_state_t cur
    );
        if (c_on)
            steer_next = ST_FORWARD;
        else if (l_on && !r_on)
            steer_next = ST_LEFT;
        else if (r_on && !l_on)
            steer_next = ST_RIGHT;
        else
            steer_next = cur;
    endfunction

endpackage

// File: rtl/track_debounce.sv
// One track sensor: 2-FF synchroniser followed by a consecutive-cycle debounce counter.
module track_debounce #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_deb
);

    localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic             r_sync_p0;
    logic             r_sync_p1;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;

    // Off-line (1) is the safe idle value for an active-low sensor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p0 <= 1'b1;
            r_sync_p1 <= 1'b1;
            r_deb     <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_sync_p0 <= i_raw;
            r_sync_p1 <= r_sync_p0;
            if (r_sync_p1 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_deb <= r_sync_p1;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/track_follow_ctrl.sv
// Line-follow controller: debounced track array -> steering FSM with lost-line search,
// hysteretic obstacle stop and a ramped motor speed command.
module track_follow_ctrl
    import car_pkg::*;
#(
    parameter int N_SENS      = 5,
    parameter int DB_CYCLES   = 1000,
    parameter int LOST_CYCLES = 50000,
    parameter int PWM_W       = 10,
    parameter int SPD_LO      = 780,
    parameter int SPD_MID     = 840,
    parameter int SPD_HI      = 870,
    parameter int TURN_DROP   = 60,
    parameter int SEARCH_SPD  = 700,
    parameter int RAMP_DIV    = 1000,
    parameter int RAMP_STEP   = 10,
    parameter int STOP_NEAR   = 24,
    parameter int STOP_FAR    = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [1:0]        speed_sel,
    input  logic [N_SENS-1:0] track,
    input  logic [7:0]        distance,
    input  logic              dist_valid,
    output logic [1:0]        dir,
    output logic [PWM_W-1:0]  speed,
    output logic              obstacle,
    output logic              lost
);

    localparam int CTR   = N_SENS / 2;
    localparam int LC_W  = $clog2(LOST_CYCLES + 1);
    localparam int DIV_W = $clog2(RAMP_DIV + 1);

    localparam int LO_TURN  = (SPD_LO  > TURN_DROP) ? SPD_LO  - TURN_DROP : 0;
    localparam int MID_TURN = (SPD_MID > TURN_DROP) ? SPD_MID - TURN_DROP : 0;
    localparam int HI_TURN  = (SPD_HI  > TURN_DROP) ? SPD_HI  - TURN_DROP : 0;

    localparam logic [7:0] NEAR_D = 8'(STOP_NEAR);
    localparam logic [7:0] FAR_D  = 8'(STOP_FAR);

    localparam logic [PWM_W-1:0]        STEP_U = PWM_W'(RAMP_STEP);
    localparam logic signed [PWM_W:0]   STEP_S = (PWM_W + 1)'(RAMP_STEP);

    logic [N_SENS-1:0] w_deb;
    logic [N_SENS-1:0] w_on;
    logic              w_c;
    logic              w_l;
    logic              w_r;
    logic              w_none;
    steer_state_t      w_steer;
    logic [PWM_W-1:0]  w_target;
    logic              w_tick;

    steer_state_t      r_state;
    logic [LC_W-1:0]   r_lost_cnt;
    logic              r_lost;
    logic              r_obst;
    logic [DIV_W-1:0]  r_div;
    logic [PWM_W-1:0]  r_speed;

    function automatic logic [PWM_W-1:0] forward_spd(input logic [1:0] sel, input logic turn);
        if (sel[1])
            forward_spd = turn ? PWM_W'(HI_TURN) : PWM_W'(SPD_HI);
        else if (sel[0])
            forward_spd = turn ? PWM_W'(MID_TURN) : PWM_W'(SPD_MID);
        else
            forward_spd = turn ? PWM_W'(LO_TURN) : PWM_W'(SPD_LO);
    endfunction

    // One ramp step toward the target; a remaining gap below the step snaps to the target.
    function automatic logic [PWM_W-1:0] ramp_toward(
        input logic [PWM_W-1:0] cur,
        input logic [PWM_W-1:0] tgt
    );
        logic signed [PWM_W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S)
            ramp_toward = cur + STEP_U;
        else if (diff < -STEP_S)
            ramp_toward = cur - STEP_U;
        else
            ramp_toward = tgt;
    endfunction

    for (genvar g = 0; g < N_SENS; g++) begin : g_db
        track_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .i_raw (track[g]),
            .o_deb (w_deb[g])
        );
    end

    // Classify the debounced on-line set (sensors are active-low).
    assign w_on    = ~w_deb;
    assign w_c     = w_on[CTR];
    assign w_l     = |w_on[N_SENS-1:CTR+1];
    assign w_r     = |w_on[CTR-1:0];
    assign w_none  = ~|w_on;
    assign w_steer = steer_next(w_c, w_l, w_r, r_state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FORWARD;
            r_lost_cnt <= '0;
            r_lost     <= 1'b0;
        end else if (w_none) begin
            if (r_state != ST_SEARCH) begin
                if (r_lost_cnt == LC_W'(LOST_CYCLES - 1)) begin
                    r_state    <= ST_SEARCH;
                    r_lost     <= 1'b1;
                    r_lost_cnt <= '0;
                end else begin
                    r_lost_cnt <= r_lost_cnt + 1'b1;
                end
            end
        end else begin
            r_lost_cnt <= '0;
            r_state    <= w_steer;
            r_lost     <= (w_steer == ST_SEARCH);
        end
    end

    // Hysteresis: only fresh readings move the flag, and only past the outer thresholds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_obst <= 1'b0;
        end else if (dist_valid) begin
            if (distance <= NEAR_D)
                r_obst <= 1'b1;
            else if (distance >= FAR_D)
                r_obst <= 1'b0;
        end
    end

    always_comb begin
        w_target = '0;
        if (run && !r_obst) begin
            case (r_state)
                ST_FORWARD: w_target = forward_spd(speed_sel, 1'b0);
                ST_LEFT,
                ST_RIGHT:   w_target = forward_spd(speed_sel, 1'b1);
                default:    w_target = PWM_W'(SEARCH_SPD);
            endcase
        end
    end

    assign w_tick = (r_div == DIV_W'(RAMP_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    // A zero target is a stop request and bypasses the ramp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_speed <= '0;
        else if (w_target == '0)
            r_speed <= '0;
        else if (w_tick)
            r_speed <= ramp_toward(r_speed, w_target);
    end

    assign dir      = r_state;
    assign speed    = r_speed;
    assign obstacle = r_obst;
    assign lost     = r_lost;

endmodule

// File: tb/tb_track_follow_ctrl.sv
// Scoreboard bench for track_follow_ctrl with shortened debounce/lost/ramp timing.
module tb_track_follow_ctrl;

    localparam int N_SENS      = 5;
    localparam int DB_CYCLES   = 8;
    localparam int LOST_CYCLES = 100;
    localparam int PWM_W       = 10;
    localparam int RAMP_DIV    = 4;
    localparam int RAMP_STEP   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [1:0]        speed_sel;
    logic [N_SENS-1:0] track;
    logic [7:0]        distance;
    logic              dist_valid;
    logic [1:0]        dir;
    logic [PWM_W-1:0]  speed;
    logic              obstacle;
    logic              lost;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb[$];

    track_follow_ctrl #(
        .N_SENS      (N_SENS),
        .DB_CYCLES   (DB_CYCLES),
        .LOST_CYCLES (LOST_CYCLES),
        .PWM_W       (PWM_W),
        .SPD_LO      (780),
        .SPD_MID     (840),
        .SPD_HI      (870),
        .TURN_DROP   (60),
        .SEARCH_SPD  (700),
        .RAMP_DIV    (RAMP_DIV),
        .RAMP_STEP   (RAMP_STEP),
        .STOP_NEAR   (24),
        .STOP_FAR    (30)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .speed_sel  (speed_sel),
        .track      (track),
        .distance   (distance),
        .dist_valid (dist_valid),
        .dir        (dir),
        .speed      (speed),
        .obstacle   (obstacle),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_speed(input string tag, input int tgt, input int bound);
        int n;
        n = 0;
        sb_push(tag, tgt);
        while (int'(speed) != tgt && n < bound) begin
            @(negedge clk);
            n++;
        end
        sb_pop(32'(speed));
    endtask

    task automatic pulse_dist(input logic [7:0] d);
        distance   = d;
        dist_valid = 1'b1;
        tick(1);
        dist_valid = 1'b0;
    endtask

    initial begin
        int prev;
        int ups;
        int viol;
        int n;

        rst        = 1'b1;
        run        = 1'b1;
        speed_sel  = 2'b10;
        track      = 5'b11011;
        distance   = 8'd100;
        dist_valid = 1'b0;
        tick(3);

        // Reset state
        sb_push("rst_dir", 3); sb_push("rst_speed", 0);
        sb_push("rst_obst", 0); sb_push("rst_lost", 0);
        sb_pop(32'(dir)); sb_pop(32'(speed)); sb_pop(32'(obstacle)); sb_pop(32'(lost));

        // 1: ramp 0 -> 870 in 87 ticks, heading forward throughout
        rst  = 1'b0;
        prev = 0; ups = 0; viol = 0; n = 0;
        while (int'(speed) != 870 && n < 87 * RAMP_DIV + 40) begin
            @(negedge clk);
            n++;
            if (int'(speed) < prev || int'(speed) - prev > RAMP_STEP || dir != 2'd3) viol++;
            if (int'(speed) != prev) ups++;
            prev = int'(speed);
        end
        sb_push("s1_speed", 870); sb_push("s1_ticks", 87); sb_push("s1_viol", 0);
        sb_pop(32'(speed)); sb_pop(32'(ups)); sb_pop(32'(viol));
        tick(3 * RAMP_DIV);
        sb_push("s1_hold", 870); sb_pop(32'(speed));

        // 2: short glitch rejected, long one steers left
        track = 5'b01111;
        tick(DB_CYCLES - 1);
        track = 5'b11011;
        sb_push("s2_glitch_dir", 3);
        tick(3 * DB_CYCLES);
        sb_pop(32'(dir));
        track = 5'b01111;
        sb_push("s2_pre_dir", 3);
        tick(DB_CYCLES + 2);
        sb_pop(32'(dir));
        sb_push("s2_left_dir", 1);
        tick(1);
        sb_pop(32'(dir));
        wait_speed("s2_turn_speed", 810, 20 * RAMP_DIV);
        tick(4 * RAMP_DIV);
        sb_push("s2_turn_hold", 810); sb_pop(32'(speed));

        // 3: line lost -> search, then recovery to the right
        track = 5'b11111;
        sb_push("s3_pre_lost", 0);
        tick(DB_CYCLES + 1 + LOST_CYCLES);
        sb_pop(32'(lost));
        sb_push("s3_lost", 1); sb_push("s3_dir", 0);
        tick(1);
        sb_pop(32'(lost)); sb_pop(32'(dir));
        wait_speed("s3_search_speed", 700, 20 * RAMP_DIV);
        track = 5'b11110;
        sb_push("s3_still_search", 0);
        tick(DB_CYCLES + 2);
        sb_pop(32'(dir));
        sb_push("s3_right_dir", 2); sb_push("s3_unlost", 0);
        tick(1);
        sb_pop(32'(dir)); sb_pop(32'(lost));

        // 4: obstacle hysteresis at mid speed
        speed_sel = 2'b01;
        track     = 5'b11011;
        sb_push("s4_fwd_dir", 3);
        tick(DB_CYCLES + 3);
        sb_pop(32'(dir));
        wait_speed("s4_speed", 840, 30 * RAMP_DIV);
        sb_push("s4_between_clear", 0);
        pulse_dist(8'd25);
        sb_pop(32'(obstacle));
        sb_push("s4_near_obst", 1);
        pulse_dist(8'd24);
        sb_pop(32'(obstacle));
        sb_push("s4_stop", 0);
        tick(1);
        sb_pop(32'(speed));
        pulse_dist(8'd27);
        sb_push("s4_between_obst", 1); sb_push("s4_between_speed", 0);
        tick(2 * RAMP_DIV);
        sb_pop(32'(obstacle)); sb_pop(32'(speed));
        sb_push("s4_far_clear", 0);
        pulse_dist(8'd30);
        sb_pop(32'(obstacle));
        n = 0;
        while (speed == '0 && n < 2 * RAMP_DIV + 2) begin
            @(negedge clk);
            n++;
        end
        sb_push("s4_ramp_restart", RAMP_STEP); sb_pop(32'(speed));

        // 5: both edges on from LEFT holds; run=0 stops at once
        track = 5'b01111;
        sb_push("s5_left", 1);
        tick(DB_CYCLES + 3);
        sb_pop(32'(dir));
        track = 5'b01110;
        sb_push("s5_hold_left", 1);
        tick(DB_CYCLES + 5);
        sb_pop(32'(dir));
        sb_push("s5_moving", 1); sb_pop(32'(speed != '0));
        run = 1'b0;
        sb_push("s5_run_stop", 0);
        tick(1);
        sb_pop(32'(speed));

        // 6: async reset mid-ramp while turning right
        run       = 1'b1;
        speed_sel = 2'b10;
        track     = 5'b11110;
        sb_push("s6_right", 2);
        tick(DB_CYCLES + 3);
        sb_pop(32'(dir));
        wait_speed("s6_speed", 500, 60 * RAMP_DIV);
        sb_push("s6_rst_dir", 3); sb_push("s6_rst_speed", 0);
        sb_push("s6_rst_obst", 0); sb_push("s6_rst_lost", 0);
        rst = 1'b1;
        #1;
        sb_pop(32'(dir)); sb_pop(32'(speed)); sb_pop(32'(obstacle)); sb_pop(32'(lost));
        @(negedge clk);
        rst = 1'b0;
        sb_push("s6_post_dir", 3);
        tick(DB_CYCLES);
        sb_pop(32'(dir));

        check_val("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "bench timeout");
    end

endmodule
